// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared types and constants for the 5-stage MIPS pipeline control.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Event counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Load-use stall, taken-branch flush and HALT drain scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_halt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             mem_branch,
    input  logic             mem_zero,
    output logic             pc_write,
    output logic             pc_src,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int            DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    state_e             state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               br_taken;
    logic               load_use;
    logic               stall_inc;
    logic               flush_inc;

    assign br_taken = mem_branch & mem_zero;
    // r0 is never a real load destination, so it can never create a hazard.
    assign load_use = ex_mem_read & (ex_rt != REG_W'(REG_ZERO)) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        pc_write     = 1'b1;
        pc_src       = 1'b0;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        halted       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_RUN: begin
                    if (br_taken) begin
                        pc_src       = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        flush_inc    = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (id_halt) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        drain_d     = DRAIN_LOAD;
                        state_d     = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Anything still in flight is older than HALT; a branch here is ignored.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    if (drain_q == '0) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
                ST_HALTED: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    halted      = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule : pipe_hazard_ctrl

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module : tb_pipe_hazard_ctrl
// Brief  : Directed scoreboard bench; a second instance uses 2-bit counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_uses_rt = 1'b0;
    logic       id_halt = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic [4:0] ex_rt = '0;
    logic       mem_branch = 1'b0;
    logic       mem_zero = 1'b0;

    logic        pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_write2, pc_src2, if_id_write2, if_id_flush2, id_ex_flush2, ex_mem_flush2, halted2;
    logic [1:0]  stall_cnt2, flush_cnt2;

    // ctrl bit order: pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, halted
    localparam logic [6:0] C_RUN    = 7'b1010000;
    localparam logic [6:0] C_STALL  = 7'b0000100;
    localparam logic [6:0] C_BRANCH = 7'b1111110;
    localparam logic [6:0] C_HALTDC = 7'b0000000;
    localparam logic [6:0] C_DRAIN  = 7'b0000100;
    localparam logic [6:0] C_HALTED = 7'b0000001;

    typedef struct {
        string       tag;
        logic [6:0]  ctrl;
        logic [15:0] s;
        logic [15:0] f;
        logic [1:0]  s2;
        logic [1:0]  f2;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_s = '0, m_f = '0;
    logic [1:0]  m_s2 = '0, m_f2 = '0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.REG_W(5), .DRAIN_CYCLES(4), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch(mem_branch),
        .mem_zero(mem_zero), .pc_write(pc_write), .pc_src(pc_src), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.REG_W(5), .DRAIN_CYCLES(4), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch(mem_branch),
        .mem_zero(mem_zero), .pc_write(pc_write2), .pc_src(pc_src2), .if_id_write(if_id_write2),
        .if_id_flush(if_id_flush2), .id_ex_flush(id_ex_flush2), .ex_mem_flush(ex_mem_flush2),
        .halted(halted2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ur, input logic hl, input logic mr, input logic [4:0] ert,
                        input logic br, input logic z, input logic [6:0] ctrl,
                        input logic s_inc, input logic f_inc, input string tag);
        exp_t e;
        exp_t got;
        logic [6:0] obs;
        logic [6:0] obs2;
        reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = ur; id_halt = hl;
        ex_mem_read = mr; ex_rt = ert; mem_branch = br; mem_zero = z;
        e.tag = tag; e.ctrl = ctrl; e.s = m_s; e.f = m_f; e.s2 = m_s2; e.f2 = m_f2;
        sb.push_back(e);
        @(negedge clock);
        got  = sb.pop_front();
        obs  = {pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, halted};
        obs2 = {pc_write2, pc_src2, if_id_write2, if_id_flush2, id_ex_flush2, ex_mem_flush2, halted2};
        n_cmp++;
        assert (obs === got.ctrl) else begin
            n_err++;
            $error("FAIL %s ctrl observed=%b expected=%b", got.tag, obs, got.ctrl);
        end
        n_cmp++;
        assert (obs2 === got.ctrl) else begin
            n_err++;
            $error("FAIL %s ctrl2 observed=%b expected=%b", got.tag, obs2, got.ctrl);
        end
        n_cmp++;
        assert (stall_cnt === got.s) else begin
            n_err++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", got.tag, stall_cnt, got.s);
        end
        n_cmp++;
        assert (flush_cnt === got.f) else begin
            n_err++;
            $error("FAIL %s flush_cnt observed=%0d expected=%0d", got.tag, flush_cnt, got.f);
        end
        n_cmp++;
        assert (stall_cnt2 === got.s2) else begin
            n_err++;
            $error("FAIL %s stall_cnt2 observed=%0d expected=%0d", got.tag, stall_cnt2, got.s2);
        end
        n_cmp++;
        assert (flush_cnt2 === got.f2) else begin
            n_err++;
            $error("FAIL %s flush_cnt2 observed=%0d expected=%0d", got.tag, flush_cnt2, got.f2);
        end
        // Counter model: takes effect at the coming edge, seen by the next step.
        if (rst) begin
            m_s = '0; m_f = '0; m_s2 = '0; m_f2 = '0;
        end else begin
            if (s_inc) begin
                if (m_s  != 16'hFFFF) m_s  = m_s + 16'd1;
                if (m_s2 != 2'd3)     m_s2 = m_s2 + 2'd1;
            end
            if (f_inc) begin
                if (m_f  != 16'hFFFF) m_f  = m_f + 16'd1;
                if (m_f2 != 2'd3)     m_f2 = m_f2 + 2'd1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clock);
        #1;
        //    rst rs     rt     ur    hl    mr    ert    br    z     ctrl      si    fi
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, "reset");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, "idle");
        step(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, C_STALL,  1'b1, 1'b0, "lu_rs");
        step(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, "lu_after");
        step(1'b0, 5'd3, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, "rt_unused");
        step(1'b0, 5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, C_STALL,  1'b1, 1'b0, "lu_rt");
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, "r0_nostall");
        step(1'b0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, C_BRANCH, 1'b0, 1'b1, "br_over_lu");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, C_BRANCH, 1'b0, 1'b1, "br_over_halt");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_RUN,    1'b0, 1'b0, "br_not_taken");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, C_STALL, 1'b1, 1'b0, "lu_sat");
        end
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, "sat_hold");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_HALTDC, 1'b0, 1'b0, "halt_dec");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, C_DRAIN,  1'b0, 1'b0, "drain0_br");
        step(1'b0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, C_DRAIN,  1'b0, 1'b0, "drain1_lu");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_DRAIN,  1'b0, 1'b0, "drain2");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_DRAIN,  1'b0, 1'b0, "drain3");
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 5'd6, 5'd0, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1, (i % 2 == 0), C_HALTED,
                 1'b0, 1'b0, "halted");
        end
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, "reset2");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, "post_reset");
        step(1'b0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, C_STALL,  1'b1, 1'b0, "lu_again");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_RUN,    1'b0, 1'b0, "final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl

`default_nettype wire
